// File: rtl/ccff_loader_pkg.sv
// Shared definitions for the configuration-chain loader: FSM states, CRC constants, default word width.
// Latency: n/a (types, constants and a combinational CRC step helper only).
// Backpressure: n/a.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [15:0] CRC_POLY       = 16'h1021;
    localparam logic [15:0] CRC_INIT       = 16'hFFFF;
    localparam int          DEFAULT_WORD_W = 8;

    // One serial step of CRC-16-CCITT, MSB-first register.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16.sv
// Serial CRC-16-CCITT accumulator, one bit per enabled cycle.
// Latency: crc updates the cycle after en; crc_next shows the value including the current bit.
// Backpressure: none; en simply gates accumulation.
// Ports: clk/rst (sync, active-high), clear (reload init), en + din (bit in),
//        crc (registered value), crc_next (value after the current bit).
module ccff_crc16
    import ccff_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc,
    output logic [15:0] crc_next
);

    assign crc_next = crc16_step(crc, din);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_next;
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams bitstream words MSB-first into a CHAIN_LEN-bit configuration chain, optional CRC readback.
// Latency: first bit on ccff_head the cycle after the first word is accepted; zero bubbles with continuous valid data.
// Backpressure: bs_ready in FETCH and on the last shift of a word; ccff_shift_en drops and ccff_head holds while starved.
// Ports: prog_clk/prog_reset (sync, active-high); start; bs_data/bs_valid/bs_ready word stream;
//        ccff_head/ccff_shift_en/ccff_tail chain interface; IO_ISOL_N, busy, done, error status.
// Build option: define CCFF_LOADER_READBACK_EN to add the VERIFY rotation and CRC compare.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = DEFAULT_WORD_W
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int                 CNT_W     = $clog2(CHAIN_LEN + 1);
    localparam int                 WCNT_W    = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WCNT_W-1:0]  WORD_BITS = WCNT_W'(WORD_W);

    state_t              state;
    state_t              state_nxt;
    logic [WORD_W-1:0]   shreg;
    logic [WCNT_W-1:0]   wcnt;      // bits of shreg not yet shifted
    logic [CNT_W-1:0]    bit_cnt;   // shifts done in the current pass (load or verify)
    logic                head_q;    // last bit driven, held while starved
    logic                done_q;
    logic                load_word;
    logic                launch;
    logic                last_bit;

    assign launch   = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_bit = (bit_cnt == LAST_BIT);

    always_comb begin
        state_nxt     = state;
        bs_ready      = 1'b0;
        ccff_shift_en = 1'b0;
        ccff_head     = head_q;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                bs_ready = 1'b1;
                if (bs_valid) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                ccff_shift_en = 1'b1;
                ccff_head     = shreg[WORD_W-1];
                if (last_bit) begin
`ifdef CCFF_LOADER_READBACK_EN
                    state_nxt = ST_VERIFY;
`else
                    state_nxt = ST_DONE;
`endif
                end else if (wcnt == WCNT_W'(1)) begin
                    // Offer the next word on the final bit so back-to-back words run without a gap.
                    bs_ready = 1'b1;
                    if (!bs_valid) state_nxt = ST_FETCH;
                end
            end
`ifdef CCFF_LOADER_READBACK_EN
            ST_VERIFY: begin
                // Rotate the chain through itself so its contents come back unchanged.
                ccff_shift_en = 1'b1;
                ccff_head     = ccff_tail;
                if (last_bit) state_nxt = ST_DONE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign load_word = bs_valid && bs_ready;

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            wcnt    <= '0;
            bit_cnt <= '0;
            head_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ccff_shift_en) head_q <= ccff_head;

            if (load_word) begin
                shreg <= bs_data;
                wcnt  <= WORD_BITS;
            end else if (state == ST_SHIFT) begin
                shreg <= shreg << 1;
                wcnt  <= wcnt - 1'b1;
            end

            // Wraps to zero after the last load shift so VERIFY reuses it.
            if (launch) begin
                bit_cnt <= '0;
            end else if (ccff_shift_en) begin
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            end

            if (launch) begin
                done_q <= 1'b0;
            end else if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
                done_q <= 1'b1;
            end
        end
    end

    assign IO_ISOL_N = (state == ST_DONE);
    assign busy      = (state == ST_FETCH) || (state == ST_SHIFT) || (state == ST_VERIFY);
    assign done      = done_q;

`ifdef CCFF_LOADER_READBACK_EN
    logic [15:0] crc_tx;
    logic [15:0] crc_rx;
    logic [15:0] crc_rx_nxt;
    logic [15:0] unused_tx_next;
    logic        err_q;

    ccff_crc16 u_crc_tx (
        .clk      (prog_clk),
        .rst      (prog_reset),
        .clear    (launch),
        .en       (ccff_shift_en && (state == ST_SHIFT)),
        .din      (ccff_head),
        .crc      (crc_tx),
        .crc_next (unused_tx_next)
    );

    ccff_crc16 u_crc_rx (
        .clk      (prog_clk),
        .rst      (prog_reset),
        .clear    (launch),
        .en       (state == ST_VERIFY),
        .din      (ccff_tail),
        .crc      (crc_rx),
        .crc_next (crc_rx_nxt)
    );

    // The final tail bit is still being accumulated on the exit cycle, so compare its next value.
    always_ff @(posedge prog_clk) begin
        if (prog_reset || launch) begin
            err_q <= 1'b0;
        end else if ((state == ST_VERIFY) && (state_nxt == ST_DONE)) begin
            err_q <= (crc_rx_nxt != crc_tx);
        end
    end

    assign error = err_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: two instances (16-bit and 12-bit chains) with loopback chain models.
// Expected chain bits are queued when a load is issued; a negedge monitor pops and compares on every shift.
// Load timing, bubble counts, chain contents and the readback flag are predicted from the word/gap stimulus.
module tb_ccff_chain_loader;

    localparam int W    = 8;
    localparam int LEN0 = 16;
    localparam int LEN1 = 12;
`ifdef CCFF_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic         prog_clk = 1'b0;
    logic         prog_reset;
    logic         start    [2];
    logic [W-1:0] bs_data  [2];
    logic         bs_valid [2];
    logic         bs_ready [2];
    logic         head     [2];
    logic         shift_en [2];
    logic         tail     [2];
    logic         isol_n   [2];
    logic         busy     [2];
    logic         done     [2];
    logic         error    [2];
    logic [15:0]  chain    [2];
    logic         flip     [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int nshift   [2];
    int bubbles  [2];
    logic last_head [2];
    bit mon_b;
    bit exp_q [$];

    always #5 prog_clk = ~prog_clk;
    always @(posedge prog_clk) cyc <= cyc + 1;

    ccff_chain_loader #(.CHAIN_LEN(LEN0), .WORD_W(W)) u_dut0 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start[0]),
        .bs_data(bs_data[0]), .bs_valid(bs_valid[0]), .bs_ready(bs_ready[0]),
        .ccff_head(head[0]), .ccff_shift_en(shift_en[0]), .ccff_tail(tail[0]),
        .IO_ISOL_N(isol_n[0]), .busy(busy[0]), .done(done[0]), .error(error[0])
    );

    ccff_chain_loader #(.CHAIN_LEN(LEN1), .WORD_W(W)) u_dut1 (
        .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start[1]),
        .bs_data(bs_data[1]), .bs_valid(bs_valid[1]), .bs_ready(bs_ready[1]),
        .ccff_head(head[1]), .ccff_shift_en(shift_en[1]), .ccff_tail(tail[1]),
        .IO_ISOL_N(isol_n[1]), .busy(busy[1]), .done(done[1]), .error(error[1])
    );

    // Loopback chain models; flip corrupts the bit leaving the tail for one cycle.
    assign tail[0] = chain[0][LEN0-1] ^ flip[0];
    assign tail[1] = chain[1][LEN1-1] ^ flip[1];

    always @(posedge prog_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (prog_reset) chain[d] <= '0;
            else if (shift_en[d]) chain[d] <= {chain[d][14:0], head[d]};
        end
    end

    function automatic int clen(input int d);
        return (d == 0) ? LEN0 : LEN1;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every shift is checked against the scoreboard (load) or the loopback (verify).
    always @(negedge prog_clk) begin
        for (int d = 0; d < 2; d++) begin
            if (prog_reset || (start[d] && !busy[d])) begin
                nshift[d]  = 0;
                bubbles[d] = 0;
            end else if (shift_en[d]) begin
                chk("shift_status", int'({isol_n[d], busy[d]}), 1);
                if (nshift[d] < clen(d)) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_shift dut=%0d actual=shift required=none", d);
                    end else begin
                        mon_b = exp_q.pop_front();
                        chk("head_bit", int'(head[d]), int'(mon_b));
                    end
                end else begin
                    chk("verify_loopback", int'(head[d]), int'(tail[d]));
                end
                last_head[d] = head[d];
                nshift[d]++;
            end else if (busy[d] && nshift[d] > 0 && nshift[d] < clen(d)) begin
                bubbles[d]++;
                chk("head_hold", int'(head[d]), int'(last_head[d]));
            end
        end
    end

    task automatic fetch_chk(input int d);
        chk("fetch_state", int'({busy[d], done[d], error[d], isol_n[d], shift_en[d]}), 5'b10000);
    endtask

    // One complete load of two words: g0/g1 are cycles the word is withheld while ready is offered.
    task automatic do_load(input int d, input logic [7:0] w0, input logic [7:0] w1,
                           input int g0, input int g1, input bit pulse, input bit flip_en);
        int L, s, g, to, n, done_cyc;
        logic [7:0]  w;
        logic [15:0] words, ev, mask;
        bit acc, first, pulsed, flipped, seen;
        L = clen(d);
        words = {w0, w1};
        ev = '0;
        for (int i = 0; i < L; i++) begin
            exp_q.push_back(words[15-i]);
            ev[L-1-i] = words[15-i];
        end
        mask = 16'((32'd1 << L) - 1);

        @(posedge prog_clk); #1;
        start[d] = 1'b1; bs_valid[d] = 1'b0; s = cyc;
        @(posedge prog_clk); #1;
        start[d] = 1'b0;
        first = 1'b1; pulsed = 1'b0; to = 0;
        for (int i = 0; i < 2; i++) begin
            g = (i == 0) ? g0 : g1;
            w = (i == 0) ? w0 : w1;
            bs_valid[d] = 1'b0;
            while (g > 0 && to < 200) begin
                @(negedge prog_clk);
                if (first) begin fetch_chk(d); first = 1'b0; end
                if (bs_ready[d]) g--;
                @(posedge prog_clk); #1; to++;
            end
            bs_valid[d] = 1'b1; bs_data[d] = w; acc = 1'b0;
            while (!acc && to < 200) begin
                if (pulse && i == 1 && !pulsed) begin start[d] = 1'b1; pulsed = 1'b1; end
                @(negedge prog_clk);
                if (first) begin fetch_chk(d); first = 1'b0; end
                acc = bs_ready[d];
                @(posedge prog_clk); #1; start[d] = 1'b0; to++;
            end
        end
        bs_valid[d] = 1'b0;
        chk("word_accept", int'(to < 200), 1);

        seen = 1'b0; n = 0; flipped = 1'b0; done_cyc = 0;
        while (!seen && n < 400) begin
            @(negedge prog_clk);
            if (done[d]) begin
                seen = 1'b1; done_cyc = cyc;
            end else begin
                @(posedge prog_clk); #1;
                flip[d] = 1'b0;
                if (flip_en && !flipped && nshift[d] == L + 3) begin
                    flip[d] = 1'b1; flipped = 1'b1;
                end
                n++;
            end
        end
        flip[d] = 1'b0;

        chk("done_seen", int'(seen), 1);
        chk("done_latency", done_cyc - s, L + 2 + g0 + g1 + (RB ? L : 0));
        chk("shift_count", nshift[d], RB ? 2 * L : L);
        chk("bubbles", bubbles[d], g1);
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        chk("done_outputs", int'({isol_n[d], busy[d]}), 2'b10);
        chk("error_flag", int'(error[d]), int'(RB && flip_en));
        if (!(RB && flip_en)) chk("chain_contents", int'(chain[d] & mask), int'(ev));
    endtask

    task automatic reset_chk(input int d);
        chk("reset_outputs",
            int'({bs_ready[d], head[d], shift_en[d], isol_n[d], busy[d], done[d], error[d]}), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int to;
        prog_reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; bs_valid[d] = 1'b0; bs_data[d] = '0; flip[d] = 1'b0;
            nshift[d] = 0; bubbles[d] = 0; last_head[d] = 1'b0;
        end
        repeat (3) @(posedge prog_clk);
        @(negedge prog_clk);
        reset_chk(0);
        reset_chk(1);
        @(posedge prog_clk); #1;
        prog_reset = 1'b0;

        do_load(0, 8'hA5, 8'h3C, 0, 0, 1'b0, 1'b0);
        do_load(0, 8'hA5, 8'h3C, 0, 3, 1'b0, 1'b0);
        do_load(1, 8'hFF, 8'h0F, 0, 0, 1'b0, 1'b0);

        // Reset in the middle of a load.
        for (int i = 0; i < 16; i++) exp_q.push_back(((16'hA53C >> (15 - i)) & 16'h1) != 0);
        @(posedge prog_clk); #1;
        start[0] = 1'b1;
        @(posedge prog_clk); #1;
        start[0] = 1'b0; bs_valid[0] = 1'b1; bs_data[0] = 8'hA5;
        to = 0;
        while (nshift[0] < 5 && to < 50) begin
            @(negedge prog_clk);
            if (bs_ready[0]) begin
                @(posedge prog_clk); #1; bs_valid[0] = 1'b0;
            end else begin
                @(posedge prog_clk); #1;
            end
            to++;
        end
        chk("reset_reach_5_shifts", int'(nshift[0] >= 5), 1);
        prog_reset = 1'b1;
        @(posedge prog_clk); #1;
        prog_reset = 1'b0;
        @(negedge prog_clk);
        reset_chk(0);
        exp_q.delete();
        do_load(0, 8'hA5, 8'h3C, 0, 0, 1'b0, 1'b0);

        do_load(0, 8'hA5, 8'h3C, 0, 0, 1'b0, 1'b0);
        do_load(0, 8'hA5, 8'h3C, 0, 0, 1'b0, RB);
        do_load(0, 8'hA5, 8'h3C, 0, 0, 1'b1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            do_load(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), RB && ($urandom_range(0, 1) == 1));
        end

        repeat (2) @(posedge prog_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64, giving the configuration-chain length in bits (minimum 1).
REQ-002 SHALL have parameter WORD_W, default 8, giving the bitstream word width.
REQ-003 SHALL have port prog_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port prog_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a load.
REQ-006 SHALL have port bs_data, input, WORD_W bits: bitstream word, MSB shifted first.
REQ-007 SHALL have port bs_valid, input, 1 bit: bs_data is valid.
REQ-008 SHALL have port bs_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-009 SHALL have port ccff_head, output, 1 bit: serial data into the chain head.
REQ-010 SHALL have port ccff_shift_en, output, 1 bit: the chain advances on this cycle.
REQ-011 SHALL have port ccff_tail, input, 1 bit: serial data returned from the chain tail.
REQ-012 SHALL have port IO_ISOL_N, output, 1 bit: IO isolation, active-low.
REQ-013 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-014 SHALL have port done, output, 1 bit: sticky load-complete flag.
REQ-015 SHALL have port error, output, 1 bit: sticky readback-mismatch flag.

Function
REQ-016 SHALL implement the state machine IDLE -> FETCH <-> SHIFT -> (VERIFY) -> DONE, where DONE -> FETCH on start.
- IDLE -> FETCH: on start.
- DONE -> FETCH: on start; this clears done and error.
REQ-017 SHALL ignore start in every state other than IDLE and DONE.
REQ-018 SHALL transfer a word on bs_valid && bs_ready.
- bs_ready is 1 in FETCH.
- bs_ready is also 1 in the last SHIFT cycle of a word when chain bits remain, so that continuous valid data produces zero bubbles.
REQ-019 SHALL start shifting an accepted word the cycle after acceptance.
- The word's MSB appears on ccff_head with ccff_shift_en=1 on that cycle.
- Each following cycle presents the next bit.
REQ-020 SHALL drive ccff_shift_en=0 and hold ccff_head whenever no data is available, and resume without losing any bit.
REQ-021 SHALL use a bit counter of width $clog2(CHAIN_LEN+1).
- It counts exactly CHAIN_LEN shift cycles.
- When CHAIN_LEN mod WORD_W != 0, the unused LSBs of the final word are discarded and never shifted.
REQ-022 SHALL, after the CHAIN_LEN-th shift, leave bs_ready=0 and enter VERIFY, or DONE when readback is not compiled.
REQ-023 SHALL hold IO_ISOL_N=0 from start until DONE is entered; IO_ISOL_N=1 in DONE.
REQ-024 SHALL hold busy=1 in FETCH, SHIFT and VERIFY, and busy=0 otherwise.

Reset
REQ-025 SHALL, on prog_reset, enter IDLE the next cycle and drive all outputs to their reset values, including when reset arrives mid-load.
- Reset values: bs_ready=0, ccff_head=0, ccff_shift_en=0, IO_ISOL_N=0, busy=0, done=0, error=0.
REQ-026 SHALL reset all counters and CRC state; a partially loaded chain is not recovered.

Configuration
REQ-027 SHALL provide readback, compiled in when CCFF_LOADER_READBACK_EN is defined.
- While shifting, compute CRC-16-CCITT (poly 0x1021, init 0xFFFF) over every bit sent.
- VERIFY then rotates the chain: CHAIN_LEN cycles with ccff_shift_en=1 and ccff_head=ccff_tail, restoring the chain contents.
- During VERIFY, compute a second CRC over ccff_tail.
- On entering DONE, set error=1 if the two CRCs differ.
REQ-028 SHALL, without CCFF_LOADER_READBACK_EN, omit the VERIFY state and CRC logic entirely and tie error to 0.

Structure
REQ-029 SHALL place the state enum, the CRC polynomial and init constants, and the default WORD_W in the shared package ccff_loader_pkg.
REQ-030 SHALL implement the CRC as a single-bit-per-cycle sub-module ccff_crc16, instantiated twice, and only when CCFF_LOADER_READBACK_EN is defined.

Verification
REQ-031 SHALL have a bench cover these scenarios:
- CHAIN_LEN=16, words 0xA5 then 0x3C back-to-back -> ccff_head = 1010010100111100 on 16 consecutive shift_en cycles; done=1 and IO_ISOL_N=1 afterwards.
- bs_valid low for 3 cycles between the two words -> ccff_shift_en=0 for exactly 3 cycles, no bit lost, same 16-bit sequence.
- CHAIN_LEN=12, words 0xFF then 0x0F -> exactly 12 shifts, sequence 111111110000; the low 4 bits of the second word are discarded.
- prog_reset asserted after 5 shifts -> next cycle all outputs equal their reset values; a new start performs a full 16-bit load.
- Readback enabled, 16-bit loopback model of the chain, words 0xA5 and 0x3C -> error=0 and chain contents preserved. The same load with one chain bit flipped during VERIFY -> error=1.
- start pulsed while busy -> ignored; shift count and the done timing unchanged.
